// File: rtl/core_run_ctrl_pkg.sv
// Shared types and LED bit positions for the core run controller.
// Build option CORE_RUN_CTRL_DEBOUNCE_EN (step button debounce) is consumed by btn_debounce.
package core_run_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        RUN     = 2'd1,
        TRAPPED = 2'd2
    } run_state_t;

    localparam int LED_TRAP   = 0;
    localparam int LED_HB     = 1;
    localparam int LED_PC_LSB = 2;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-FF synchroniser, optional debounce (CORE_RUN_CTRL_DEBOUNCE_EN), registered rising-edge pulse.
// Latency: level 2 cycles after raw (plus DB_CYCLES when filtered and debounced); pulse 1 cycle after level.
// Backpressure: none; the pulse is a single-cycle strobe the consumer must take or lose.
module btn_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter bit FILTER    = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       synced;
    logic       cond;
    logic       cond_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign synced = sync_q[1];

    generate
        if (FILTER) begin : g_filter
`ifdef CORE_RUN_CTRL_DEBOUNCE_EN
            localparam int CNT_W = $clog2(DB_CYCLES + 1);
            logic [CNT_W-1:0] db_cnt;
            logic             db_level;

            // Any sample agreeing with the current level restarts the stability window.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    db_cnt   <= '0;
                    db_level <= 1'b0;
                end else if (synced == db_level) begin
                    db_cnt <= '0;
                end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
                    db_cnt   <= '0;
                    db_level <= synced;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end

            assign cond = db_level;
`else
            assign cond = synced;
`endif
        end else begin : g_plain
            assign cond = synced;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cond_d <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            cond_d <= cond;
            pulse  <= cond & ~cond_d;
        end
    end

    assign level = cond;

endmodule

// File: rtl/core_run_ctrl.sv
// Purpose: run/halt/step/trap controller producing a one-cycle core clock enable, plus a paged PC LED view.
// Latency: enable 1 cycle after tick/step; LEDs 1 cycle after inputs. Backpressure: none, free-running.
// Option: CORE_RUN_CTRL_DEBOUNCE_EN enables the step button debounce window of DB_CYCLES cycles.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int DIV_MIN   = 4,
    parameter int RATE_W    = 2,
    parameter int PC_W      = 32,
    parameter int LED_W     = 12,
    parameter int PAGE_W    = 2,
    parameter int DB_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic [PAGE_W-1:0] page_i,
    input  logic              trap_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              core_ce_o,
    output logic [LED_W-1:0]  led_o
);

    localparam int CNT_W = DIV_MIN + 2**RATE_W - 1;
    localparam int PCF_W = LED_W - 2;
    localparam int EXT_W = PC_W + PCF_W;
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    run_state_t       state;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] tick_mask;
    logic             tick;
    logic             run_s;
    logic             step_pulse;
    logic             unused_run_rise;
    logic             unused_step_level;
    logic [EXT_W-1:0] pc_ext;
    logic [PCF_W-1:0] pc_field;

    // The run switch only needs synchronising, never debouncing.
    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .FILTER    (1'b0)
    ) u_run_sync (
        .clk    (clk),
        .resetn (resetn),
        .raw    (run_i),
        .level  (run_s),
        .pulse  (unused_run_rise)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .FILTER    (1'b1)
    ) u_step (
        .clk    (clk),
        .resetn (resetn),
        .raw    (step_i),
        .level  (unused_step_level),
        .pulse  (step_pulse)
    );

    assign tick_mask = ~(ALL_ONES << (DIV_MIN + int'(rate_i)));
    assign tick      = (div_cnt & tick_mask) == tick_mask;

    // Zero-extend so pages beyond the top of the PC read as 0.
    assign pc_ext   = EXT_W'(pc_i);
    assign pc_field = PCF_W'(pc_ext >> (int'(page_i) * PCF_W));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= HALT;
            div_cnt   <= '0;
            core_ce_o <= 1'b0;
            led_o     <= '0;
        end else begin
            div_cnt   <= div_cnt + CNT_W'(1);
            core_ce_o <= 1'b0;

            led_o[LED_TRAP]                <= trap_i || (state == TRAPPED);
            led_o[LED_HB]                  <= led_o[LED_HB] ^ core_ce_o;
            led_o[LED_W-1:LED_PC_LSB]      <= pc_field;

            if (trap_i) begin
                state <= TRAPPED;
            end else begin
                case (state)
                    HALT: begin
                        // A step coinciding with the run edge is dropped.
                        if (run_s) begin
                            state   <= RUN;
                            div_cnt <= '0;
                        end else begin
                            core_ce_o <= step_pulse;
                        end
                    end
                    RUN: begin
                        core_ce_o <= tick;
                        if (!run_s) begin
                            state <= HALT;
                        end
                    end
                    default: begin
                        state <= TRAPPED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed sequences, a PC page vector table and a randomized run against a reference model.
module tb_core_run_ctrl;

    localparam int DIV_MIN   = 4;
    localparam int RATE_W    = 2;
    localparam int PC_W      = 32;
    localparam int LED_W     = 12;
    localparam int PAGE_W    = 2;
    localparam int DB_CYCLES = 8;
    localparam int PCF       = LED_W - 2;
    localparam int DIV_WRAP  = 1 << (DIV_MIN + 2**RATE_W - 1);
`ifdef CORE_RUN_CTRL_DEBOUNCE_EN
    localparam int STEP_DLY  = 3 + DB_CYCLES;
    localparam int HOLD      = DB_CYCLES + 4;
`else
    localparam int STEP_DLY  = 3;
    localparam int HOLD      = 4;
`endif

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic              run_i  = 1'b0;
    logic              step_i = 1'b0;
    logic              trap_i = 1'b0;
    logic [RATE_W-1:0] rate_i = '0;
    logic [PAGE_W-1:0] page_i = '0;
    logic [PC_W-1:0]   pc_i   = '0;
    logic              core_ce_o;
    logic [LED_W-1:0]  led_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    core_run_ctrl #(
        .DIV_MIN   (DIV_MIN),
        .RATE_W    (RATE_W),
        .PC_W      (PC_W),
        .LED_W     (LED_W),
        .PAGE_W    (PAGE_W),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .run_i     (run_i),
        .step_i    (step_i),
        .rate_i    (rate_i),
        .page_i    (page_i),
        .trap_i    (trap_i),
        .pc_i      (pc_i),
        .core_ce_o (core_ce_o),
        .led_o     (led_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic edge1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        edge1();
        edge1();
        check("reset_ce", core_ce_o, 1'b0);
        check("reset_led", led_o, '0);
        resetn = 1'b1;
    endtask

    // Reference model: inputs seen at edge e via per-edge history, divider as an elapsed-cycle count.
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_TRAP = 2;
    bit run_h[$];
    bit step_h[$];
    int m_mode;
    int m_div;
    bit m_ce;
    bit m_hb;

    function automatic bit past_run(int i);
        return (i < 0) ? 1'b0 : run_h[i];
    endfunction

    function automatic bit past_step(int i);
        return (i < 0) ? 1'b0 : step_h[i];
    endfunction

    task automatic model_reset();
        run_h.delete();
        step_h.delete();
        m_mode = M_HALT;
        m_div  = 0;
        m_ce   = 1'b0;
        m_hb   = 1'b0;
    endtask

    task automatic model_edge(output bit e_ce, output logic [LED_W-1:0] e_led);
        int idx, period;
        bit rs, sp, tk, trap_seen;
        longint unsigned pcf;
        idx = run_h.size();
        run_h.push_back(run_i);
        step_h.push_back(step_i);
        rs        = past_run(idx - 2);
        sp        = past_step(idx - 3) && !past_step(idx - 4);
        period    = 1 << (DIV_MIN + int'(rate_i));
        tk        = (m_div % period) == period - 1;
        trap_seen = trap_i || (m_mode == M_TRAP);
        e_ce      = 1'b0;
        m_hb      = m_hb ^ m_ce;
        m_div     = (m_div + 1) % DIV_WRAP;
        if (trap_i) begin
            m_mode = M_TRAP;
        end else if (m_mode == M_HALT) begin
            if (rs) begin
                m_mode = M_RUN;
                m_div  = 0;
            end else begin
                e_ce = sp;
            end
        end else if (m_mode == M_RUN) begin
            e_ce = tk;
            if (!rs) m_mode = M_HALT;
        end
        m_ce  = e_ce;
        pcf   = (64'(pc_i) >> (int'(page_i) * PCF)) & ((64'd1 << PCF) - 1);
        e_led = {pcf[PCF-1:0], m_hb, trap_seen};
    endtask

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [PAGE_W-1:0] page;
        logic [PCF-1:0]    field;
    } pc_vec_t;

    pc_vec_t vt[7];

    initial begin
        int n_hb, n_pulse;
        bit e_ce;
        logic [LED_W-1:0] e_led;
        bit bounce[5];

        vt[0] = '{32'h0000_0ABC, 2'd0, 10'h2BC};
        vt[1] = '{32'h0000_0ABC, 2'd1, 10'h002};
        vt[2] = '{32'h0000_0ABC, 2'd2, 10'h000};
        vt[3] = '{32'hFFFF_FFFF, 2'd3, 10'h003};
        vt[4] = '{32'h1234_5678, 2'd1, 10'h115};
        vt[5] = '{32'h1234_5678, 2'd2, 10'h123};
        vt[6] = '{32'hFFFF_FFFF, 2'd0, 10'h3FF};

        // Run from reset at rate 0, then switch to rate 3 mid-run.
        run_i  = 1'b1;
        rate_i = 2'd0;
        do_reset();
        n_hb = 0;
        for (int e = 1; e <= 262; e++) begin
            bit want;
            edge1();
            if (e <= 68) want = (e >= 19) && ((e - 19) % 16 == 0);
            else         want = (e == 131) || (e == 259);
            check("run_ce", core_ce_o, want);
            check("run_hb", led_o[1], n_hb % 2);
            check("run_trap_led", led_o[0], 1'b0);
            if (want) n_hb++;
            if (e == 68) rate_i = 2'd3;
        end

        // PC page vectors while halted.
        run_i  = 1'b0;
        rate_i = 2'd0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pc_i   = vt[i].pc;
            page_i = vt[i].page;
            edge1();
            check("pc_page", led_o[LED_W-1:2], vt[i].field);
            check("pc_status", led_o[1:0], 2'b00);
        end

        // Three step presses while halted.
        do_reset();
        n_pulse = 0;
        for (int p = 0; p < 3; p++) begin
            step_i = 1'b1;
            for (int e = 1; e <= 2 * HOLD; e++) begin
                edge1();
                check("step_ce", core_ce_o, e == STEP_DLY + 1);
                if (core_ce_o) n_pulse++;
                if (e == HOLD) step_i = 1'b0;
            end
        end
        check("step_count", n_pulse, 3);
        check("step_hb", led_o[1], 1'b1);

        // Step pulse lands on the same edge as the run rise: step dropped.
        do_reset();
        for (int e = 1; e <= STEP_DLY + 20; e++) begin
            if (e == 1) step_i = 1'b1;
            if (e == STEP_DLY - 1) run_i = 1'b1;
            edge1();
            check("sim_run_step_ce", core_ce_o, e == STEP_DLY + 17);
        end
        step_i = 1'b0;
        run_i  = 1'b0;

`ifdef CORE_RUN_CTRL_DEBOUNCE_EN
        // Bouncing press 1-1-0-0-1 then steady: one enable, 11 cycles after the last rise.
        do_reset();
        bounce = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int e = 1; e <= 30; e++) begin
            step_i = (e <= 5) ? bounce[e-1] : 1'b1;
            edge1();
            check("bounce_ce", core_ce_o, e == 16);
        end
        step_i = 1'b0;
`endif

        // Async reset at an enable, then a trap on the tick edge.
        run_i = 1'b1;
        do_reset();
        for (int e = 1; e <= 19; e++) edge1();
        check("pre_trap_ce", core_ce_o, 1'b1);
        resetn = 1'b0;
        #1;
        check("async_rst_ce", core_ce_o, 1'b0);
        check("async_rst_led", led_o, '0);
        edge1();
        resetn = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            edge1();
            check("pre_trap_quiet", core_ce_o, 1'b0);
        end
        trap_i = 1'b1;
        edge1();
        check("trap_tick_ce", core_ce_o, 1'b0);
        check("trap_led", led_o[0], 1'b1);
        trap_i = 1'b0;
        for (int e = 1; e <= 40 + 2 * HOLD; e++) begin
            if (e == 10) run_i = 1'b0;
            if (e == 20) run_i = 1'b1;
            if (e == 30) step_i = 1'b1;
            if (e == 30 + HOLD) step_i = 1'b0;
            edge1();
            check("trapped_ce", core_ce_o, 1'b0);
            check("trapped_led", led_o[0], 1'b1);
        end
        do_reset();
        for (int e = 1; e <= 19; e++) begin
            edge1();
            check("post_trap_ce", core_ce_o, e == 19);
        end

        // Randomized segments against the reference model.
        for (int seg = 0; seg < 4; seg++) begin
            run_i  = 1'($urandom_range(0, 1));
            step_i = 1'b0;
            trap_i = 1'b0;
            rate_i = RATE_W'($urandom_range(0, 3));
            do_reset();
            model_reset();
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 99) == 0) run_i = ~run_i;
`ifndef CORE_RUN_CTRL_DEBOUNCE_EN
                if ($urandom_range(0, 3) == 0) step_i = ~step_i;
`endif
                if ($urandom_range(0, 199) == 0) rate_i = RATE_W'($urandom_range(0, 3));
                trap_i = ($urandom_range(0, 999) == 0);
                page_i = PAGE_W'($urandom_range(0, 3));
                pc_i   = $urandom;
                model_edge(e_ce, e_led);
                edge1();
                check("rand_ce", core_ce_o, e_ce);
                check("rand_led", led_o, e_led);
            end
            trap_i = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
